// File: rtl/inst_fetch_buffer.sv
// Byte-serial instruction fetch with little-endian word assembly,
// a small prefetch FIFO, data-side yield and branch redirect flush.
module inst_fetch_buffer #(
    parameter int                ADDR_W     = 32,
    parameter int                INST_BYTES = 4,
    parameter int                FIFO_DEPTH = 2,
    parameter logic [ADDR_W-1:0] RESET_PC   = '0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    mem_busy_i,
    output logic                    mem_req_o,
    output logic [ADDR_W-1:0]       mem_addr_o,
    input  logic                    mem_gnt_i,
    input  logic                    mem_rvalid_i,
    input  logic [7:0]              mem_rdata_i,
    input  logic                    redirect_i,
    input  logic [ADDR_W-1:0]       redirect_pc_i,
    output logic                    inst_valid_o,
    output logic [8*INST_BYTES-1:0] inst_o,
    output logic [ADDR_W-1:0]       pc_o,
    input  logic                    inst_ready_i
);

    localparam int IW = 8 * INST_BYTES;
    localparam int BW = (INST_BYTES > 1) ? $clog2(INST_BYTES) : 1;
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int DW = $clog2(FIFO_DEPTH * INST_BYTES) + 4;
    localparam logic [BW-1:0] LAST_IDX = BW'(INST_BYTES - 1);

    logic [ADDR_W-1:0] r_fetch_pc;
    logic [BW-1:0]     r_byte_idx;
    logic [BW-1:0]     r_rx_idx;
    logic [IW-1:0]     r_asm;
    logic [IW-1:0]     r_inst [FIFO_DEPTH];
    logic [ADDR_W-1:0] r_pc   [FIFO_DEPTH];
    logic [PW-1:0]     r_wptr;
    logic [PW-1:0]     r_rptr;
    logic [CW-1:0]     r_count;
    logic [ADDR_W-1:0] r_ppc  [FIFO_DEPTH];
    logic [PW-1:0]     r_ppc_wptr;
    logic [PW-1:0]     r_ppc_rptr;
    logic [CW-1:0]     r_words_pend;
    logic [DW-1:0]     r_outst;
    logic [DW-1:0]     r_drop;

    logic          w_word_open;
    logic          w_req;
    logic          w_acc;
    logic          w_acc_first;
    logic          w_acc_last;
    logic          w_rx;
    logic          w_push;
    logic          w_valid;
    logic          w_pop;
    logic [IW-1:0] w_word;

    // A FIFO slot is reserved when the first byte of a word issues
    assign w_word_open = (r_byte_idx != '0) ||
                         (({1'b0, r_count} + {1'b0, r_words_pend}) < (CW+1)'(FIFO_DEPTH));
    assign w_req       = !rst && !redirect_i && !mem_busy_i && w_word_open;
    assign w_acc       = w_req && mem_gnt_i;
    assign w_acc_first = w_acc && (r_byte_idx == '0);
    assign w_acc_last  = w_acc && (r_byte_idx == LAST_IDX);
    assign w_rx        = mem_rvalid_i && (r_drop == '0);
    assign w_push      = w_rx && (r_rx_idx == LAST_IDX);
    assign w_valid     = (r_count != '0);
    assign w_pop       = w_valid && inst_ready_i;

    always_comb begin
        w_word = r_asm;
        w_word[{r_rx_idx, 3'b000} +: 8] = mem_rdata_i;
    end

    assign mem_req_o    = w_req;
    assign mem_addr_o   = rst ? '0 : r_fetch_pc + ADDR_W'(r_byte_idx);
    assign inst_valid_o = !rst && w_valid;
    assign inst_o       = rst ? '0 : r_inst[r_rptr];
    assign pc_o         = rst ? '0 : r_pc[r_rptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fetch_pc   <= RESET_PC;
            r_byte_idx   <= '0;
            r_rx_idx     <= '0;
            r_asm        <= '0;
            r_wptr       <= '0;
            r_rptr       <= '0;
            r_count      <= '0;
            r_ppc_wptr   <= '0;
            r_ppc_rptr   <= '0;
            r_words_pend <= '0;
            r_outst      <= '0;
            r_drop       <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_inst[i] <= '0;
                r_pc[i]   <= '0;
                r_ppc[i]  <= '0;
            end
        end else if (redirect_i) begin
            r_fetch_pc   <= redirect_pc_i;
            r_byte_idx   <= '0;
            r_rx_idx     <= '0;
            r_asm        <= '0;
            r_wptr       <= '0;
            r_rptr       <= '0;
            r_count      <= '0;
            r_ppc_wptr   <= '0;
            r_ppc_rptr   <= '0;
            r_words_pend <= '0;
            // Everything still outstanding belongs to the old stream
            r_outst      <= r_outst - DW'(mem_rvalid_i);
            r_drop       <= r_outst - DW'(mem_rvalid_i);
        end else begin
            if (w_acc) begin
                if (w_acc_last) begin
                    r_byte_idx          <= '0;
                    r_fetch_pc          <= r_fetch_pc + ADDR_W'(INST_BYTES);
                    r_ppc[r_ppc_wptr]   <= r_fetch_pc;
                    r_ppc_wptr          <= r_ppc_wptr + PW'(1);
                end else begin
                    r_byte_idx <= r_byte_idx + BW'(1);
                end
            end
            r_outst <= r_outst + DW'(w_acc) - DW'(mem_rvalid_i);
            if (mem_rvalid_i && (r_drop != '0)) begin
                r_drop <= r_drop - DW'(1);
            end
            if (w_rx) begin
                if (w_push) begin
                    r_rx_idx       <= '0;
                    r_asm          <= '0;
                    r_inst[r_wptr] <= w_word;
                    r_pc[r_wptr]   <= r_ppc[r_ppc_rptr];
                    r_wptr         <= r_wptr + PW'(1);
                    r_ppc_rptr     <= r_ppc_rptr + PW'(1);
                end else begin
                    r_rx_idx <= r_rx_idx + BW'(1);
                    r_asm    <= w_word;
                end
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PW'(1);
            end
            r_count      <= r_count + CW'(w_push) - CW'(w_pop);
            r_words_pend <= r_words_pend + CW'(w_acc_first) - CW'(w_push);
        end
    end

endmodule

// File: tb/tb_inst_fetch_buffer.sv
// Directed scoreboard bench for inst_fetch_buffer: default build plus
// a 16-bit / 2-byte build for address wrap.
module tb_inst_fetch_buffer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, busy, gnt, rvalid, redirect, ready;
    logic [7:0]  rdata;
    logic [31:0] rpc;
    logic        req, valid;
    logic [31:0] addr, inst, pc;

    logic        rst2, busy2, gnt2, rvalid2, redirect2, ready2;
    logic [7:0]  rdata2;
    logic [15:0] rpc2;
    logic        req2, valid2;
    logic [15:0] addr2, inst2, pc2;

    inst_fetch_buffer u1 (
        .clk(clk), .rst(rst), .mem_busy_i(busy), .mem_req_o(req),
        .mem_addr_o(addr), .mem_gnt_i(gnt), .mem_rvalid_i(rvalid),
        .mem_rdata_i(rdata), .redirect_i(redirect), .redirect_pc_i(rpc),
        .inst_valid_o(valid), .inst_o(inst), .pc_o(pc),
        .inst_ready_i(ready)
    );

    inst_fetch_buffer #(
        .ADDR_W(16), .INST_BYTES(2), .FIFO_DEPTH(2), .RESET_PC(16'hFFFE)
    ) u2 (
        .clk(clk), .rst(rst2), .mem_busy_i(busy2), .mem_req_o(req2),
        .mem_addr_o(addr2), .mem_gnt_i(gnt2), .mem_rvalid_i(rvalid2),
        .mem_rdata_i(rdata2), .redirect_i(redirect2), .redirect_pc_i(rpc2),
        .inst_valid_o(valid2), .inst_o(inst2), .pc_o(pc2),
        .inst_ready_i(ready2)
    );

    typedef struct { logic [31:0] inst; logic [31:0] pc; } exp_t;
    typedef struct { int due; logic [7:0] d; } rsp_t;

    exp_t        expq[$];
    rsp_t        rspq[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          lat = 1;
    int          last_due = 0;
    int          nb = 0;
    int          npop = 0;
    int          n, k;
    logic [31:0] exp_addr, wacc, wpc;
    logic        p2;
    logic [15:0] pa2;
    logic [15:0] ea [4];

    function automatic logic [7:0] mbyte(logic [31:0] a);
        if (a < 4) return (a == 0) ? 8'h13 : 8'h00;
        return 8'(a * 37 + 11);
    endfunction

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One cycle of u1: scoreboard, memory model, advance to next negedge
    task automatic step();
        int due;
        #1;
        if (valid) begin
            if (expq.size() == 0) begin
                chk("stale_valid", valid, 0);
            end else if (ready) begin
                chk("inst", inst, expq[0].inst);
                chk("pc", pc, expq[0].pc);
                void'(expq.pop_front());
                npop++;
            end
        end
        if (req && gnt) begin
            chk("addr", addr, exp_addr);
            if (nb == 0) wpc = exp_addr;
            wacc[8*nb +: 8] = mbyte(exp_addr);
            exp_addr = exp_addr + 1;
            nb++;
            if (nb == 4) begin
                expq.push_back('{wacc, wpc});
                nb = 0;
            end
            due = cyc + lat;
            if (due <= last_due) due = last_due + 1;
            last_due = due;
            rspq.push_back('{due, mbyte(addr)});
        end
        if (redirect) begin
            expq.delete();
            nb = 0;
            exp_addr = rpc;
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
        rvalid = 1'b0;
        rdata  = 8'h00;
        if (rspq.size() > 0 && rspq[0].due == cyc) begin
            rvalid = 1'b1;
            rdata  = rspq[0].d;
            void'(rspq.pop_front());
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1; busy = 0; gnt = 1; rvalid = 0; rdata = 0;
        redirect = 0; rpc = 0; ready = 0;
        rst2 = 1; busy2 = 0; gnt2 = 1; rvalid2 = 0; rdata2 = 0;
        redirect2 = 0; rpc2 = 0; ready2 = 0;
        exp_addr = 0; wacc = 0; wpc = 0;
        ea[0] = 16'hFFFE; ea[1] = 16'hFFFF; ea[2] = 16'h0000; ea[3] = 16'h0001;

        @(negedge clk); @(negedge clk); #1;
        chk("rst_req", req, 0);
        chk("rst_addr", addr, 0);
        chk("rst_valid", valid, 0);
        chk("rst_inst", inst, 0);
        chk("rst_pc", pc, 0);
        @(negedge clk);
        rst = 0;

        // Idle memctrl: addresses 0..3, word visible one cycle after byte 4
        repeat (4) step();
        #1 chk("t1_not_yet", valid, 0);
        step();
        #1;
        chk("t1_valid", valid, 1);
        chk("t1_inst", inst, 32'h0000_0013);
        chk("t1_pc", pc, 0);

        // Ready held low: FIFO of two fills, then fetch stalls
        repeat (3) step();
        for (int i = 0; i < 4; i++) begin
            #1 chk("t2_stall", req, 0);
            step();
        end
        ready = 1;
        step();
        ready = 0;
        #1;
        chk("t2_resume_req", req, 1);
        chk("t2_resume_addr", addr, 8);

        // Busy for three cycles after byte 1 of the word at PC 8
        step();
        ready = 1;
        step();
        busy = 1;
        for (int i = 0; i < 3; i++) begin
            #1 chk("t3_busy", req, 0);
            step();
        end
        busy = 0;
        #1;
        chk("t3_resume_req", req, 1);
        chk("t3_resume_addr", addr, 10);
        repeat (12) step();

        // Long latency so bytes are in flight at the redirect
        lat = 3;
        repeat (8) step();
        redirect = 1; rpc = 32'h100;
        step();
        redirect = 0;
        #1;
        chk("t4_req", req, 1);
        chk("t4_addr", addr, 32'h100);
        chk("t4_flushed", valid, 0);
        n = 0;
        while (!valid && n < 40) begin
            step();
            n++;
        end
        chk("t4_timeout", n < 40, 1);
        chk("t4_first_pc", pc, 32'h100);
        repeat (10) step();

        // Redirect together with a pop and a returning byte
        lat = 1;
        repeat (10) step();
        n = 0;
        while (!(valid && rvalid) && n < 30) begin
            step();
            n++;
        end
        chk("t5_timeout", n < 30, 1);
        redirect = 1; rpc = 32'h200;
        step();
        redirect = 0;
        #1 chk("t5_flushed", valid, 0);
        repeat (20) step();
        chk("pops_seen", npop >= 10, 1);

        // 16-bit address space, 2-byte instructions: wrap past 0xFFFF
        rst2 = 0;
        k = 0;
        pa2 = 0;
        for (int i = 0; i < 10; i++) begin
            #1;
            p2 = req2 & gnt2;
            if (p2) begin
                if (k < 4) chk("t6_addr", addr2, ea[k]);
                else chk("t6_extra_req", req2, 0);
                k++;
                pa2 = addr2;
            end
            @(posedge clk);
            @(negedge clk);
            rvalid2 = p2;
            rdata2  = mbyte({16'h0, pa2});
        end
        rvalid2 = 0;
        chk("t6_nreq", k, 4);
        #1;
        chk("t6_valid", valid2, 1);
        chk("t6_pc0", pc2, 16'hFFFE);
        chk("t6_inst0", inst2, {mbyte(32'hFFFF), mbyte(32'hFFFE)});
        ready2 = 1;
        @(posedge clk);
        @(negedge clk);
        ready2 = 0;
        #1;
        chk("t6_pc1", pc2, 16'h0000);
        chk("t6_inst1", inst2, {mbyte(32'h1), mbyte(32'h0)});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
